// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game status/direction encodings and score helpers
package game_pkg;

   localparam logic [1:0] PAUSED       = 2'b00;
   localparam logic [1:0] PLAYING      = 2'b01;
   localparam logic [1:0] DIE_FLASHING = 2'b10;
   localparam logic [1:0] INITIALIZING = 2'b11;

   localparam logic [1:0] UP    = 2'b00;
   localparam logic [1:0] RIGHT = 2'b01;
   localparam logic [1:0] DOWN  = 2'b10;
   localparam logic [1:0] LEFT  = 2'b11;

   localparam int MAX_LEN = 32;

   typedef enum logic [1:0] {
      S_PAUSED       = 2'b00,
      S_PLAYING      = 2'b01,
      S_DIE_FLASHING = 2'b10,
      S_INITIALIZING = 2'b11
   } game_state_e;

   function automatic logic [2:0] popcount5(input logic [4:0] v);
      popcount5 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]);
   endfunction

   // Digit-by-digit ripple add; a carry out of the top digit pins the result at 9999.
   function automatic logic [15:0] bcd_add_sat(input logic [15:0] v, input logic [2:0] n);
      logic [4:0]  c;
      logic [4:0]  d;
      logic [4:0]  t;
      logic [15:0] r;
      c = {2'b00, n};
      r = '0;
      for (int i = 0; i < 4; i++) begin
         d = {1'b0, v[4*i +: 4]} + c;
         if (d > 5'd9) begin
            t = d - 5'd10;
            r[4*i +: 4] = t[3:0];
            c = 5'd1;
         end else begin
            r[4*i +: 4] = d[3:0];
            c = 5'd0;
         end
      end
      bcd_add_sat = (c != 5'd0) ? 16'h9999 : r;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronise a raw button, require it stable, pulse on accepted press
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_in,
   output logic pulse_out
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic          stable_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          flip;

   // The run counter restarts whenever the synchronised level agrees with the accepted one.
   always_comb begin
      flip      = (sync2_q != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
      cnt_d     = '0;
      stable_d  = stable_q;
      if (sync2_q != stable_q) begin
         if (flip) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      pulse_out = flip & sync2_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= btn_in;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game sequencer: status FSM, BCD score/high score, snake length, win detect
module game_ctrl
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int INIT_CYCLES     = 4,
   parameter int FLASH_CYCLES    = 40000000,
   parameter int FLASH_TIMES     = 4,
   parameter int MAX_LEN         = game_pkg::MAX_LEN
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        btn_start,
   input  logic        hit_wall,
   input  logic        hit_itself,
   input  logic [4:0]  get_apple,
   output logic [1:0]  game_status,
   output logic [15:0] score_bcd,
   output logic [15:0] high_score_bcd,
   output logic [5:0]  snake_len,
   output logic        game_won
);

   localparam logic [31:0] INIT_LAST  = 32'(INIT_CYCLES - 1);
   localparam logic [31:0] FLASH_LAST = 32'(FLASH_CYCLES * FLASH_TIMES - 1);
   localparam logic [5:0]  LEN_MAX    = 6'(MAX_LEN);
   localparam logic [5:0]  LEN_START  = 6'd3;

   game_state_e state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        new_game_q, new_game_d;
   logic [15:0] score_q, score_d;
   logic [15:0] high_q, high_d;
   logic [5:0]  len_q, len_d;
   logic        won_q, won_d;
   logic [4:0]  apple_q;

   logic        start_pulse;
   logic [4:0]  apple_rise;
   logic [2:0]  apple_cnt;
   logic [6:0]  len_sum;
   logic        hit;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_start_db (
      .clock    (clock),
      .reset    (reset),
      .btn_in   (btn_start),
      .pulse_out(start_pulse)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      new_game_d = new_game_q;
      score_d    = score_q;
      high_d     = high_q;
      len_d      = len_q;
      won_d      = won_q;

      apple_rise = get_apple & ~apple_q;
      apple_cnt  = popcount5(apple_rise);
      len_sum    = {1'b0, len_q} + 7'(apple_cnt);
      hit        = hit_wall | hit_itself;

      case (state_q)
         S_INITIALIZING: begin
            if (cnt_q == INIT_LAST) begin
               state_d    = S_PAUSED;
               new_game_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_PAUSED: begin
            if (start_pulse) begin
               state_d = S_PLAYING;
               if (new_game_q) begin
                  score_d    = '0;
                  len_d      = LEN_START;
                  won_d      = 1'b0;
                  new_game_d = 1'b0;
               end
            end
         end
         S_PLAYING: begin
            // A hit in the same cycle as an apple edge forfeits the apple.
            if (!hit) begin
               score_d = bcd_add_sat(score_q, apple_cnt);
               len_d   = (len_sum > {1'b0, LEN_MAX}) ? LEN_MAX : len_sum[5:0];
            end
            if (hit) begin
               state_d = S_DIE_FLASHING;
            end else if (len_q == LEN_MAX) begin
               state_d = S_DIE_FLASHING;
               won_d   = 1'b1;
            end else if (start_pulse) begin
               state_d = S_PAUSED;
            end
            if (state_d == S_DIE_FLASHING && score_d > high_q) begin
               high_d = score_d;
            end
         end
         S_DIE_FLASHING: begin
            if (cnt_q == FLASH_LAST) begin
               state_d = S_INITIALIZING;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = S_INITIALIZING;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_INITIALIZING;
         cnt_q      <= '0;
         new_game_q <= 1'b1;
         score_q    <= '0;
         high_q     <= '0;
         len_q      <= LEN_START;
         won_q      <= 1'b0;
         apple_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         new_game_q <= new_game_d;
         score_q    <= score_d;
         high_q     <= high_d;
         len_q      <= len_d;
         won_q      <= won_d;
         apple_q    <= get_apple;
      end
   end

   assign game_status    = state_q;
   assign score_bcd      = score_q;
   assign high_score_bcd = high_q;
   assign snake_len      = len_q;
   assign game_won       = won_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scoreboard bench for game_ctrl against a decimal-arithmetic reference model
module tb_game_ctrl;

   localparam int DB   = 4;
   localparam int INIT = 4;
   localparam int FC   = 10;
   localparam int FT   = 2;
   localparam int ML   = 32;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        btn_start = 1'b0;
   logic        hit_wall = 1'b0;
   logic        hit_itself = 1'b0;
   logic [4:0]  get_apple = 5'd0;
   logic [1:0]  game_status;
   logic [15:0] score_bcd;
   logic [15:0] high_score_bcd;
   logic [5:0]  snake_len;
   logic        game_won;

   game_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .INIT_CYCLES    (INIT),
      .FLASH_CYCLES   (FC),
      .FLASH_TIMES    (FT),
      .MAX_LEN        (ML)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .btn_start     (btn_start),
      .hit_wall      (hit_wall),
      .hit_itself    (hit_itself),
      .get_apple     (get_apple),
      .game_status   (game_status),
      .score_bcd     (score_bcd),
      .high_score_bcd(high_score_bcd),
      .snake_len     (snake_len),
      .game_won      (game_won)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0]  st;
      logic [15:0] sc;
      logic [15:0] hi;
      logic [5:0]  len;
      logic        won;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail = 0;

   // Reference model state: plain integers, status as 0..3, score kept in decimal.
   int   m_st, m_cnt, m_score, m_high, m_len;
   bit   m_new, m_won, m_stable;
   bit   m_samp[8];
   logic [4:0] m_prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      m_st = 3; m_cnt = 0; m_score = 0; m_high = 0; m_len = 3;
      m_new = 1; m_won = 0; m_stable = 0; m_prev = 5'd0;
      for (int i = 0; i < 8; i++) m_samp[i] = 1'b0;
   endtask

   // Drive one cycle of inputs, predict the state after the next clock edge, queue it.
   task automatic step(input bit b, input bit hw, input bit hi, input logic [4:0] ap);
      bit         pulse, all_hi, all_diff, hitc;
      int         n, old_len;
      logic [4:0] rise;
      exp_t       e;
      btn_start = b; hit_wall = hw; hit_itself = hi; get_apple = ap;
      all_hi = 1; all_diff = 1;
      for (int i = 1; i <= DB; i++) begin
         if (!m_samp[i]) all_hi = 0;
         if (m_samp[i] == m_stable) all_diff = 0;
      end
      pulse = all_diff && all_hi;
      if (all_diff) m_stable = !m_stable;
      for (int i = DB + 1; i > 0; i--) m_samp[i] = m_samp[i-1];
      m_samp[0] = b;
      rise = ap & ~m_prev;
      m_prev = ap;
      n = $countones(rise);
      hitc = hw || hi;
      case (m_st)
         3: if (m_cnt == INIT - 1) begin m_st = 0; m_cnt = 0; m_new = 1; end else m_cnt++;
         0: if (pulse) begin
               m_st = 1;
               if (m_new) begin m_score = 0; m_len = 3; m_won = 0; m_new = 0; end
            end
         1: begin
               old_len = m_len;
               if (!hitc) begin
                  m_score = (m_score + n > 9999) ? 9999 : m_score + n;
                  m_len   = (m_len + n > ML) ? ML : m_len + n;
               end
               if (hitc || old_len == ML) begin
                  if (!hitc) m_won = 1;
                  m_st = 2;
                  if (m_score > m_high) m_high = m_score;
               end else if (pulse) begin
                  m_st = 0;
               end
            end
         default: if (m_cnt == FC * FT - 1) begin m_st = 3; m_cnt = 0; end else m_cnt++;
      endcase
      e.st = 2'(m_st); e.sc = to_bcd(m_score); e.hi = to_bcd(m_high);
      e.len = 6'(m_len); e.won = m_won;
      exp_q.push_back(e);
      @(negedge clock);
   endtask

   always @(posedge clock) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("status", 32'(game_status), 32'(mon_e.st));
         chk("score", 32'(score_bcd), 32'(mon_e.sc));
         chk("high_score", 32'(high_score_bcd), 32'(mon_e.hi));
         chk("snake_len", 32'(snake_len), 32'(mon_e.len));
         chk("game_won", 32'(game_won), 32'(mon_e.won));
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected end of test");
      $fatal(1);
   end

   initial begin
      int  lat;
      bit  found;
      bit  lvl;
      int  hold;

      model_reset();
      repeat (3) @(negedge clock);
      chk("rst_status", 32'(game_status), 32'h3);
      chk("rst_score", 32'(score_bcd), 32'h0);
      chk("rst_high", 32'(high_score_bcd), 32'h0);
      chk("rst_len", 32'(snake_len), 32'd3);
      chk("rst_won", 32'(game_won), 32'h0);
      reset = 1'b0;

      repeat (12) step(0, 0, 0, 5'd0);
      chk("idle_paused", 32'(game_status), 32'h0);

      repeat (2) step(1, 0, 0, 5'd0);
      repeat (12) step(0, 0, 0, 5'd0);
      chk("glitch_ignored", 32'(game_status), 32'h0);

      lat = 0; found = 0;
      for (int i = 0; i < 30; i++) begin
         step(i < 20, 0, 0, 5'd0);
         if (!found && game_status == 2'b01) begin found = 1; lat = i + 1; end
      end
      chk("start_latency", 32'(lat), 32'd6);
      chk("held_one_pulse", 32'(game_status), 32'h1);

      step(0, 0, 0, 5'b00001); step(0, 0, 0, 5'b00000);
      step(0, 0, 0, 5'b00001); step(0, 0, 0, 5'b00000);
      step(0, 0, 0, 5'b10100); step(0, 0, 0, 5'b00000);
      chk("score_4", 32'(score_bcd), 32'h0004);
      chk("len_7", 32'(snake_len), 32'd7);
      repeat (10) begin step(0, 0, 0, 5'b00001); step(0, 0, 0, 5'b00000); end
      chk("score_14", 32'(score_bcd), 32'h0014);

      step(0, 1, 0, 5'b00010);
      chk("hit_status", 32'(game_status), 32'h2);
      chk("hit_score_kept", 32'(score_bcd), 32'h0014);
      repeat (28) step(0, 0, 0, 5'd0);
      chk("after_die_paused", 32'(game_status), 32'h0);
      chk("high_14", 32'(high_score_bcd), 32'h0014);
      repeat (8) step(1, 0, 0, 5'd0);
      repeat (4) step(0, 0, 0, 5'd0);
      chk("new_game_score", 32'(score_bcd), 32'h0);
      chk("new_game_len", 32'(snake_len), 32'd3);

      repeat (28) begin step(0, 0, 0, 5'b00001); step(0, 0, 0, 5'b00000); end
      step(0, 0, 0, 5'b00001);
      chk("len_full", 32'(snake_len), 32'd32);
      chk("full_still_playing", 32'(game_status), 32'h1);
      step(0, 0, 0, 5'b00000);
      chk("win_status", 32'(game_status), 32'h2);
      chk("win_flag", 32'(game_won), 32'h1);
      repeat (26) step(0, 0, 0, 5'd0);
      chk("win_held_paused", 32'(game_won), 32'h1);
      repeat (8) step(1, 0, 0, 5'd0);
      repeat (4) step(0, 0, 0, 5'd0);
      chk("win_cleared", 32'(game_won), 32'h0);

      lvl = 0; hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin lvl = !lvl; hold = int'($urandom_range(1, 15)); end
         hold--;
         step(lvl, $urandom_range(0, 99) == 0, $urandom_range(0, 99) == 0, 5'($urandom));
      end
      repeat (10) step(0, 0, 0, 5'd0);

      chk("bcd_carry", 32'(game_pkg::bcd_add_sat(16'h0009, 3'd1)), 32'h0010);
      chk("bcd_ripple", 32'(game_pkg::bcd_add_sat(16'h0099, 3'd5)), 32'h0104);
      chk("bcd_sat_9998", 32'(game_pkg::bcd_add_sat(16'h9998, 3'd5)), 32'h9999);
      chk("bcd_sat_9995", 32'(game_pkg::bcd_add_sat(16'h9995, 3'd5)), 32'h9999);

      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         step((i % 16) < 8, 0, 0, 5'd0);
         if (game_status == 2'b01) found = 1;
      end
      chk("reach_playing", 32'(found), 32'h1);
      step(0, 1, 0, 5'd0);
      repeat (5) step(0, 0, 0, 5'd0);
      chk("pre_reset_dying", 32'(game_status), 32'h2);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_status", 32'(game_status), 32'h3);
      chk("midrst_high", 32'(high_score_bcd), 32'h0);
      chk("midrst_score", 32'(score_bcd), 32'h0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      repeat (10) step(0, 0, 0, 5'd0);
      chk("post_reset_paused", 32'(game_status), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
